// File: rtl/uart_pkg.sv
// uart_pkg: FSM encoding and line/parity constants for uart_tx; PARITY state exists only with UART_TX_PARITY_EN
package uart_pkg;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
endpackage

// File: rtl/uart_tx_baud_cnt.sv
// uart_tx_baud_cnt: bit-period counter, bit_done on the last cycle of each bit
module uart_tx_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign bit_done = enable && cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) cnt <= '0;
    else if (clear || bit_done) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, LSB first, one idle cycle between back-to-back frames; UART_TX_PARITY_EN adds par_typ and a parity bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                  par_typ,
`endif
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int IW = $clog2(DATA_WIDTH);
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_r;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] data_r;
  logic [IW-1:0] bit_idx;
  logic bit_done, line_nxt, accept;
  assign tx_ready = Rst && state == IDLE;
  assign accept = tx_valid && tx_ready;
  uart_tx_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk(Clk),
    .Rst(Rst),
    .clear(state == IDLE),
    .enable(state != IDLE),
    .bit_done(bit_done)
  );
  // line_nxt is the level of the current state; registering it keeps tx_out glitch-free one cycle behind state
  always_comb begin
    state_nxt = state;
    line_nxt = IDLE_LVL;
    case (state)
      IDLE: state_nxt = accept ? START : IDLE;
      START: begin
        state_nxt = bit_done ? DATA : START;
        line_nxt = START_LVL;
      end
      DATA: begin
        state_nxt = bit_done && bit_idx == IW'(DATA_WIDTH - 1) ? AFTER_DATA : DATA;
        line_nxt = data_r[bit_idx];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_nxt = bit_done ? STOP : PARITY;
        line_nxt = ^data_r ^ par_r;
      end
`endif
      STOP: state_nxt = bit_done ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      tx_out <= IDLE_LVL;
      busy <= 1'b0;
      data_r <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      par_r <= PAR_EVEN;
`endif
    end else begin
      state <= state_nxt;
      tx_out <= line_nxt;
      busy <= state != IDLE;
      bit_idx <= state != DATA ? '0 : bit_done ? bit_idx + 1'b1 : bit_idx;
      if (accept) data_r <= tx_data;
`ifdef UART_TX_PARITY_EN
      if (accept) par_r <= par_typ;
`endif
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam logic [10:0] ALL = 11'((1 << NB) - 1);
  logic clk = 1'b0, rst = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_out, busy;
`ifdef UART_TX_PARITY_EN
  logic par_typ = 1'b0;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .Clk(clk),
    .Rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
`ifdef UART_TX_PARITY_EN
    .par_typ(par_typ),
`endif
    .tx_ready(tx_ready),
    .tx_out(tx_out),
    .busy(busy)
  );
  // expected frame, bit 0 = start bit; parity is even (par_typ=0)
  function automatic logic [10:0] frm(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction
  task automatic capture(output logic [10:0] bits, output logic [10:0] stab, output int wait_cyc, output int bsy);
    bits = '0;
    stab = '0;
    bsy = 0;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (tx_out !== 1'b0 && wait_cyc < 300);
    for (int k = 0; k < NB * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k % CPB == 0) begin
        bits[k / CPB] = tx_out;
        stab[k / CPB] = 1'b1;
      end else if (tx_out !== bits[k / CPB]) stab[k / CPB] = 1'b0;
      if (busy === 1'b1) bsy++;
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL rst_tx_out got=%b exp=1", tx_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", tx_ready); end
    rst = 1'b1;
    #1;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", tx_ready); end
  endtask
  task automatic test_frame;
    logic [10:0] b, s;
    int w, bs;
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    capture(b, s, w, bs);
    total++; if (w !== 1) begin bad++; $display("FAIL frame_latency got=%0d exp=1", w); end
    total++; if (b !== frm(8'hA5)) begin bad++; $display("FAIL frame_a5 got=%h exp=%h", b, frm(8'hA5)); end
    total++; if (s !== ALL) begin bad++; $display("FAIL frame_bit_len got=%h exp=%h", s, ALL); end
    total++; if (bs !== NB * CPB) begin bad++; $display("FAIL frame_busy got=%0d exp=%0d", bs, NB * CPB); end
    @(negedge clk);
    total++; if ({tx_out, busy, tx_ready} !== 3'b101) begin bad++; $display("FAIL frame_after got=%b exp=101", {tx_out, busy, tx_ready}); end
  endtask
  task automatic test_back_to_back;
    logic [10:0] b1, s1, b2, s2;
    int w1, bs1, w2, bs2, lows;
    @(negedge clk);
    fork
      begin
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hFF;
        repeat (NB * CPB + 1) @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        capture(b1, s1, w1, bs1);
        capture(b2, s2, w2, bs2);
      end
    join
    total++; if (b1 !== frm(8'h3C)) begin bad++; $display("FAIL b2b_first got=%h exp=%h", b1, frm(8'h3C)); end
    total++; if (w2 !== 2) begin bad++; $display("FAIL b2b_gap got=%0d exp=2", w2); end
    total++; if (b2 !== frm(8'hFF)) begin bad++; $display("FAIL b2b_second got=%h exp=%h", b2, frm(8'hFF)); end
    total++; if ((s1 & s2) !== ALL) begin bad++; $display("FAIL b2b_bit_len got=%h exp=%h", s1 & s2, ALL); end
    lows = 0;
    repeat (2 * NB * CPB) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL b2b_no_third got=%0d exp=0", lows); end
  endtask
  task automatic test_ignored;
    logic [10:0] b, s;
    int w, bs, lows;
    @(negedge clk);
    fork
      begin
        tx_data = 8'h0F;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (16) @(negedge clk);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL ign_ready got=%b exp=0", tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
      end
      capture(b, s, w, bs);
    join
    total++; if (b !== frm(8'h0F)) begin bad++; $display("FAIL ign_frame got=%h exp=%h", b, frm(8'h0F)); end
    lows = 0;
    repeat (3 * NB * CPB) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL ign_idle got=%0d exp=0", lows); end
  endtask
  task automatic test_reset_mid;
    logic [10:0] b, s;
    int w, bs;
    @(negedge clk);
    tx_data = 8'hF0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    total++; if (tx_out !== 1'b0) begin bad++; $display("FAIL mid_bit3 got=%b exp=0", tx_out); end
    rst = 1'b0;
    #1;
    total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL mid_async_line got=%b exp=1", tx_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", tx_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_release_ready got=%b exp=1", tx_ready); end
    tx_data = 8'h81;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    capture(b, s, w, bs);
    total++; if (w !== 1) begin bad++; $display("FAIL mid_latency got=%0d exp=1", w); end
    total++; if (b !== frm(8'h81)) begin bad++; $display("FAIL mid_frame_81 got=%h exp=%h", b, frm(8'h81)); end
  endtask
  task automatic test_hold;
    logic [10:0] b, s;
    int w, bs;
    @(negedge clk);
    tx_data = 8'h12;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b0;
    capture(b, s, w, bs);
    total++; if (b !== frm(8'h12)) begin bad++; $display("FAIL hold_frame got=%h exp=%h", b, frm(8'h12)); end
    total++; if (s !== ALL) begin bad++; $display("FAIL hold_bit_len got=%h exp=%h", s, ALL); end
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] pd[3] = '{8'hA5, 8'hA5, 8'h00};
    logic pt[3] = '{1'b0, 1'b1, 1'b1};
    logic pe[3] = '{1'b0, 1'b1, 1'b1};
    logic [10:0] b, s, e;
    int w, bs;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tx_data = pd[i];
      par_typ = pt[i];
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      par_typ = ~pt[i];
      capture(b, s, w, bs);
      e = {1'b1, pe[i], pd[i], 1'b0};
      total++; if (b !== e) begin bad++; $display("FAIL parity_%0d got=%h exp=%h", i, b, e); end
      repeat (4) @(negedge clk);
    end
    par_typ = 1'b0;
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_hold();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, Clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter: DATA_WIDTH, 8, data bits per frame; legal range 5..8.
REQ-003 Port: Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: Rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: tx_data  input  DATA_WIDTH  byte to send; sampled only on acceptance.
REQ-006 Port: tx_valid  input  1  request to send tx_data.
REQ-007 Port: par_typ  input  1  parity type, 0 even, 1 odd; present only with UART_TX_PARITY_EN; sampled on acceptance.
REQ-008 Port: tx_ready  output  1  high when a request can be accepted.
REQ-009 Port: tx_out  output  1  serial line; idle level 1.
REQ-010 Port: busy  output  1  high from the first cycle of the start bit through the last cycle of the stop bit.

Function
REQ-011 Acceptance SHALL occur in a cycle where tx_valid=1 and tx_ready=1; tx_data and par_typ are latched internally at that edge.
REQ-012 tx_ready SHALL be 1 only in IDLE; tx_valid is ignored in every other state, and no request is queued.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (parity build only), STOP.
REQ-014 Transitions: IDLE->START on acceptance; START->DATA, DATA->PARITY or STOP, PARITY->STOP, STOP->IDLE, each after CLKS_PER_BIT cycles in the bit.
REQ-015 DATA SHALL stay in that state for DATA_WIDTH bit periods.
REQ-016 Line levels: IDLE=1, START=0, DATA=latched bits LSB first, PARITY=parity bit, STOP=1.
REQ-017 tx_out SHALL fall on the first rising edge after the acceptance edge, with latency 1 cycle.
REQ-018 Every bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-019 tx_out SHALL be a registered output and free of glitches.
REQ-020 Parity bit SHALL be the XOR-reduction of the latched data, XORed with the latched par_typ.
REQ-021 Baud counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-022 Baud counter SHALL count 0..CLKS_PER_BIT-1, clear at every bit boundary, and never wrap mid-bit.
REQ-023 Bit index counter width SHALL be $clog2(DATA_WIDTH).
REQ-024 Back-to-back: tx_ready SHALL rise the cycle after STOP ends.
REQ-025 Back-to-back: with tx_valid held high, the next start bit SHALL begin 1 cycle after that, so exactly one idle-high cycle separates frames.
REQ-026 Changes on tx_data and par_typ after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-027 Rst low SHALL immediately force: state=IDLE, tx_out=1, tx_ready=0 while asserted, busy=0, counters=0, data register=0.
REQ-028 After Rst deassertion, tx_ready SHALL be 1 in the first clock cycle.
REQ-029 Reset mid-frame SHALL abort the frame with no resumption; the line returns high asynchronously.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: par_typ port and PARITY state exist; frame = 1 start + DATA_WIDTH data + 1 parity + 1 stop bits.
REQ-031 Macro UART_TX_PARITY_EN undefined: no par_typ port and no PARITY state; frame = 1 start + DATA_WIDTH data + 1 stop bits; DATA goes directly to STOP.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state encoding, the line-level constants IDLE_LVL=1 and START_LVL=0, and the parity-type constants PAR_EVEN=0 and PAR_ODD=1.
REQ-033 Sub-module uart_tx_baud_cnt SHALL provide the bit-period counter: inputs clear and enable, output bit_done, asserted on count CLKS_PER_BIT-1.

Verification
REQ-034 Scenario (no parity, CLKS_PER_BIT=4): accept 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy high for 40 cycles.
REQ-035 Scenario (parity build): 0xA5 with par_typ=0 -> parity bit 0; 0xA5 with par_typ=1 -> parity bit 1; 0x00 with par_typ=1 -> parity bit 1.
REQ-036 Scenario (back-to-back): tx_valid held high with 0x3C then 0xFF -> exactly 1 idle-high cycle between the stop bit of 0x3C and the start bit of 0xFF.
REQ-037 Scenario (ignored request): pulse tx_valid with 0x55 during the DATA state of 0x0F -> only 0x0F is transmitted, then the line stays idle.
REQ-038 Scenario (reset mid-frame): assert Rst during data bit 3 -> tx_out=1 without waiting for a clock edge; after release, 0x81 transmits correctly.
REQ-039 Scenario (input hold): change tx_data from 0x12 to 0xED one cycle after accepting 0x12 -> line carries 0x12.
